// File: rtl/reset_pkg.sv
// Shared encodings for the multi-output reset sequencer.
// Channel state values are visible on state_o.
package reset_pkg;

  localparam int ST_W   = 2;
  localparam int DROP_W = 8;

  typedef enum logic [ST_W-1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/reset_channel.sv
// One reset channel: WAIT/HOLD/RUN FSM with a hold counter.
// reset_o is high in WAIT and HOLD, low in RUN.
module reset_channel
  import reset_pkg::*;
#(
  parameter int unsigned          HOLD_BITS = 22,
  parameter logic [HOLD_BITS-1:0] H         = '0
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      ok_i,
  input  logic      soft_hit_i,
  output ch_state_e state_o,
  output logic      reset_o
);

  ch_state_e            state_q, state_d;
  logic [HOLD_BITS-1:0] cnt_q, cnt_d;
  logic                 rst_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= (state_d != ST_RUN);
    end
  end

  // Soft hit outranks every other transition, including WAIT->HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_WAIT: begin
        cnt_d = '0;
        if (!soft_hit_i && ok_i) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (soft_hit_i || !ok_i) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == H) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (soft_hit_i || !ok_i) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign state_o = state_q;
  assign reset_o = rst_q;

endmodule

// File: rtl/reset_sequencer.sv
// Multi-output reset sequencer: synchronised ready gating, chained
// release, delayed soft reset and lock-loss monitoring.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned NUM_RST   = 3,
  parameter int unsigned NUM_RDY   = 5,
  parameter logic [NUM_RST*NUM_RDY-1:0] RDY_MASK = '1,
  parameter int unsigned HOLD_BITS = 22,
  parameter logic [NUM_RST*HOLD_BITS-1:0] HOLD_CNT =
    {22'd4194303, 22'd31, 22'd31},
  parameter int unsigned SEQUENTIAL = 1,
  parameter int unsigned SOFT_DLY   = 1023,
  parameter logic [NUM_RST-1:0] SOFT_MASK = 3'b100
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    soft_reset_i,
  input  logic                    clear_i,
  input  logic [NUM_RDY-1:0]      ready_i,
  output logic [NUM_RST-1:0]      reset_o,
  output logic [ST_W*NUM_RST-1:0] state_o,
  output logic                    soft_pending_o,
  output logic [DROP_W-1:0]       drop_cnt_o,
  output logic [NUM_RDY-1:0]      drop_src_o
);

  localparam logic [9:0]        DLY      = 10'(SOFT_DLY);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [NUM_RDY-1:0] rdy_m_q, rdy_s_q;
  logic [9:0]         dly_q, dly_d;
  logic               strobe_q, strobe_d;
  logic [DROP_W-1:0]  dcnt_q, dcnt_d;
  logic [NUM_RDY-1:0] dsrc_q, dsrc_d, src_set;
  logic [NUM_RST-1:0] own_ok, ok, run, soft_hit;
  logic               drop_ev;
  ch_state_e          st [NUM_RST];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rdy_m_q  <= '0;
      rdy_s_q  <= '0;
      dly_q    <= '0;
      strobe_q <= 1'b0;
      dcnt_q   <= '0;
      dsrc_q   <= '0;
    end else begin
      rdy_m_q  <= ready_i;
      rdy_s_q  <= rdy_m_q;
      dly_q    <= dly_d;
      strobe_q <= strobe_d;
      dcnt_q   <= dcnt_d;
      dsrc_q   <= dsrc_d;
    end
  end

  for (genvar k = 0; k < NUM_RST; k++) begin : g_ch
    localparam logic [HOLD_BITS-1:0] HK =
      HOLD_CNT[k*HOLD_BITS +: HOLD_BITS];

    assign own_ok[k] =
      &(rdy_s_q | ~RDY_MASK[k*NUM_RDY +: NUM_RDY]);

    if (SEQUENTIAL != 0 && k > 0) begin : g_seq
      assign ok[k] = own_ok[k] & run[k-1];
    end else begin : g_par
      assign ok[k] = own_ok[k];
    end

    assign soft_hit[k] = strobe_q & SOFT_MASK[k];

    reset_channel #(
      .HOLD_BITS (HOLD_BITS),
      .H         (HK)
    ) u_ch (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .ok_i       (ok[k]),
      .soft_hit_i (soft_hit[k]),
      .state_o    (st[k]),
      .reset_o    (reset_o[k])
    );

    assign run[k] = (st[k] == ST_RUN);
    assign state_o[k*ST_W +: ST_W] = st[k];
  end

  // A retrigger reloads the delay, so only the final countdown strobes.
  always_comb begin
    dly_d = dly_q;
    if (soft_reset_i) begin
      dly_d = DLY;
    end else if (dly_q != '0) begin
      dly_d = dly_q - 10'd1;
    end
    strobe_d = (dly_d == 10'd1);
  end

  // Only a channel's own ready loss counts; soft and cascade exits do not.
  always_comb begin
    drop_ev = |(run & ~own_ok & ~soft_hit);
    src_set = '0;
    for (int j = 0; j < int'(NUM_RDY); j++) begin
      for (int k = 0; k < int'(NUM_RST); k++) begin
        if (!rdy_s_q[j] && run[k] && RDY_MASK[k*NUM_RDY+j]) begin
          src_set[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    dcnt_d = dcnt_q;
    dsrc_d = dsrc_q | src_set;
    if (clear_i) begin
      dcnt_d = '0;
      dsrc_d = '0;
    end else if (drop_ev && dcnt_q != DROP_MAX) begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  assign soft_pending_o = (dly_q != '0);
  assign drop_cnt_o     = dcnt_q;
  assign drop_src_o     = dsrc_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed latency scenarios plus a
// randomized run against a streak-based behavioural model.
module tb_reset_sequencer;

  localparam int NR = 3;
  localparam int NY = 2;
  localparam int SDLY = 8;
  localparam logic [2:0] SMASK = 3'b100;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          soft_reset_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [NY-1:0] ready_i = '0;
  logic [NR-1:0] reset_o;
  logic [2*NR-1:0] state_o;
  logic          soft_pending_o;
  logic [7:0]    drop_cnt_o;
  logic [NY-1:0] drop_src_o;

  int errors = 0;
  int checks = 0;

  reset_sequencer #(
    .NUM_RST    (NR),
    .NUM_RDY    (NY),
    .RDY_MASK   ('1),
    .HOLD_BITS  (4),
    .HOLD_CNT   ({4'd1, 4'd2, 4'd3}),
    .SEQUENTIAL (1),
    .SOFT_DLY   (SDLY),
    .SOFT_MASK  (SMASK)
  ) dut (
    .clock_i        (clk),
    .reset_i        (reset_i),
    .soft_reset_i   (soft_reset_i),
    .clear_i        (clear_i),
    .ready_i        (ready_i),
    .reset_o        (reset_o),
    .state_o        (state_o),
    .soft_pending_o (soft_pending_o),
    .drop_cnt_o     (drop_cnt_o),
    .drop_src_o     (drop_src_o)
  );

  always #5 clk = ~clk;

  // Model: a channel is released once ok has held (with no soft hit)
  // for H+2 consecutive edges; the first such edge puts it in HOLD.
  int      hk [NR] = '{3, 2, 1};
  int      streak [NR];
  bit      run_m [NR];
  logic [NY-1:0] rs1_m, rs2_m;
  bit      soft_valid;
  int      last_soft;
  int      ecount = 0;
  int      dcnt_m;
  logic [NY-1:0] dsrc_m;
  bit      pend_m;

  task automatic model_reset();
    for (int k = 0; k < NR; k++) begin
      streak[k] = 0;
      run_m[k] = 1'b0;
    end
    rs1_m = '0;
    rs2_m = '0;
    soft_valid = 1'b0;
    last_soft = 0;
    dcnt_m = 0;
    dsrc_m = '0;
    pend_m = 1'b0;
  endtask

  task automatic model_edge();
    bit own, any_run, ev;
    bit ok [NR];
    bit hit [NR];
    ecount++;
    if (reset_i) begin
      model_reset();
      return;
    end
    own = &rs2_m;
    any_run = 1'b0;
    ev = 1'b0;
    for (int k = 0; k < NR; k++) begin
      ok[k] = own && (k == 0 || run_m[k-1]);
      hit[k] = soft_valid && (ecount == last_soft + SDLY)
               && SMASK[k];
      if (run_m[k]) any_run = 1'b1;
      if (run_m[k] && !own && !hit[k]) ev = 1'b1;
    end
    for (int k = 0; k < NR; k++) begin
      if (hit[k] || !ok[k]) streak[k] = 0;
      else if (streak[k] < 1000) streak[k]++;
      run_m[k] = (streak[k] >= hk[k] + 2);
    end
    if (clear_i) begin
      dcnt_m = 0;
      dsrc_m = '0;
    end else begin
      if (ev && dcnt_m < 255) dcnt_m++;
      if (any_run) dsrc_m = dsrc_m | ~rs2_m;
    end
    if (soft_reset_i) begin
      soft_valid = 1'b1;
      last_soft = ecount;
    end
    pend_m = soft_valid && (ecount - last_soft) < SDLY;
    rs2_m = rs1_m;
    rs1_m = ready_i;
  endtask

  function automatic logic [NR-1:0] m_rst();
    logic [NR-1:0] r;
    for (int k = 0; k < NR; k++) r[k] = !run_m[k];
    return r;
  endfunction

  function automatic logic [2*NR-1:0] m_state();
    logic [2*NR-1:0] s;
    for (int k = 0; k < NR; k++) begin
      s[2*k +: 2] = run_m[k] ? 2'd2 : (streak[k] > 0 ? 2'd1 : 2'd0);
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    ready_i = '0;
    model_reset();
    repeat (3) step();
    checks++;
    if (reset_o !== 3'b111) begin
      errors++;
      $display("FAIL reset_rst got %b want 111", reset_o);
    end
    checks++;
    if (state_o !== 6'd0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", state_o);
    end
    checks++;
    if ({soft_pending_o, drop_cnt_o, drop_src_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_misc got %b/%0d/%b want 0/0/00",
               soft_pending_o, drop_cnt_o, drop_src_o);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_release(input string tag);
    logic [NR-1:0] want;
    ready_i = 2'b11;
    for (int i = 0; i < 16; i++) begin
      step();
      want = {i < 13, i < 10, i < 6};
      checks++;
      if (reset_o !== want) begin
        errors++;
        $display("FAIL %s S0+%0d reset_o got %b want %b",
                 tag, i, reset_o, want);
      end
      checks++;
      if (state_o !== m_state()) begin
        errors++;
        $display("FAIL %s S0+%0d state_o got %h want %h",
                 tag, i, state_o, m_state());
      end
    end
  endtask

  task automatic test_drop();
    logic [NR-1:0] want;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    ready_i = 2'b01;
    step();
    ready_i = 2'b11;
    for (int i = 1; i < 17; i++) begin
      step();
      want = {i >= 2 && i < 14, i >= 2 && i < 11, i >= 2 && i < 7};
      checks++;
      if (reset_o !== want) begin
        errors++;
        $display("FAIL drop S0+%0d reset_o got %b want %b",
                 i, reset_o, want);
      end
    end
    checks++;
    if (drop_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL drop_cnt got %0d want 1", drop_cnt_o);
    end
    checks++;
    if (drop_src_o !== 2'b10) begin
      errors++;
      $display("FAIL drop_src got %b want 10", drop_src_o);
    end
  endtask

  task automatic test_soft();
    logic [NR-1:0] want;
    soft_reset_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      soft_reset_i = 1'b0;
      want = {i >= 8 && i <= 10, 2'b00};
      checks++;
      if (reset_o !== want) begin
        errors++;
        $display("FAIL soft T+%0d reset_o got %b want %b",
                 i, reset_o, want);
      end
      checks++;
      if (soft_pending_o !== (i < 8)) begin
        errors++;
        $display("FAIL soft T+%0d pending got %b want %b",
                 i, soft_pending_o, i < 8);
      end
    end
    checks++;
    if (drop_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL soft_drop_cnt got %0d want 1", drop_cnt_o);
    end
  endtask

  task automatic test_soft_retrigger();
    logic [NR-1:0] want;
    soft_reset_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      soft_reset_i = (i == 4);
      want = {i >= 13 && i <= 15, 2'b00};
      checks++;
      if (reset_o !== want) begin
        errors++;
        $display("FAIL retrig T+%0d reset_o got %b want %b",
                 i, reset_o, want);
      end
      checks++;
      if (soft_pending_o !== (i < 13)) begin
        errors++;
        $display("FAIL retrig T+%0d pending got %b want %b",
                 i, soft_pending_o, i < 13);
      end
    end
  endtask

  task automatic test_saturate();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    for (int g = 1; g <= 300; g++) begin
      ready_i = 2'b01;
      step();
      ready_i = 2'b11;
      repeat (11) step();
      if (g == 100) begin
        checks++;
        if (drop_cnt_o !== 8'd100) begin
          errors++;
          $display("FAIL sat_mid got %0d want 100", drop_cnt_o);
        end
      end
    end
    checks++;
    if (drop_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL sat_cnt got %0d want 255", drop_cnt_o);
    end
    ready_i = 2'b01;
    step();
    ready_i = 2'b11;
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++;
    if ({reset_o[0], drop_cnt_o, drop_src_o} !== {1'b1, 10'd0}) begin
      errors++;
      $display("FAIL clear_win got rst0=%b cnt=%0d src=%b want 1/0/00",
               reset_o[0], drop_cnt_o, drop_src_o);
    end
    step();
    checks++;
    if ({drop_cnt_o, drop_src_o} !== 10'd0) begin
      errors++;
      $display("FAIL clear_after got cnt=%0d src=%b want 0/00",
               drop_cnt_o, drop_src_o);
    end
  endtask

  task automatic test_async_reset();
    repeat (16) step();
    checks++;
    if (reset_o !== 3'b000) begin
      errors++;
      $display("FAIL async_pre got %b want 000", reset_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({reset_o, state_o} !== {3'b111, 6'd0}) begin
      errors++;
      $display("FAIL async_run got %b/%h want 111/0", reset_o, state_o);
    end
    step();
    step();
    reset_i = 1'b0;
    repeat (4) step();
    checks++;
    if (state_o[1:0] !== 2'd1) begin
      errors++;
      $display("FAIL async_hold_pre got %0d want 1", state_o[1:0]);
    end
    #2;
    reset_i = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({reset_o, state_o} !== {3'b111, 6'd0}) begin
      errors++;
      $display("FAIL async_hold got %b/%h want 111/0", reset_o, state_o);
    end
    step();
    reset_i = 1'b0;
    test_release("restart");
  endtask

  task automatic test_random();
    int glitch = 0;
    for (int i = 0; i < 600; i++) begin
      if (glitch == 0 && $urandom_range(0, 14) == 0) begin
        glitch = int'($urandom_range(1, 3));
      end
      if (glitch > 0) begin
        ready_i = 2'($urandom_range(0, 2));
        glitch--;
      end else begin
        ready_i = 2'b11;
      end
      soft_reset_i = ($urandom_range(0, 39) == 0);
      clear_i = ($urandom_range(0, 59) == 0);
      step();
      checks++;
      if (reset_o !== m_rst()) begin
        errors++;
        $display("FAIL rnd%0d reset_o got %b want %b",
                 i, reset_o, m_rst());
      end
      checks++;
      if (state_o !== m_state()) begin
        errors++;
        $display("FAIL rnd%0d state_o got %h want %h",
                 i, state_o, m_state());
      end
      checks++;
      if (soft_pending_o !== pend_m) begin
        errors++;
        $display("FAIL rnd%0d pending got %b want %b",
                 i, soft_pending_o, pend_m);
      end
      checks++;
      if (drop_cnt_o !== 8'(dcnt_m)) begin
        errors++;
        $display("FAIL rnd%0d drop_cnt got %0d want %0d",
                 i, drop_cnt_o, dcnt_m);
      end
      checks++;
      if (drop_src_o !== dsrc_m) begin
        errors++;
        $display("FAIL rnd%0d drop_src got %b want %b",
                 i, drop_src_o, dsrc_m);
      end
    end
    soft_reset_i = 1'b0;
    clear_i = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_release("release");
    test_drop();
    test_soft();
    test_soft_retrigger();
    test_saturate();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule
